// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: button channel indices
// and the per-channel press state machine encoding.
package calc_pkg;

  // Button channel indices into btn_raw / btn_level / btn_pulse
  localparam int BTN_C  = 0;
  localparam int BTN_AC = 1;
  localparam int BTN_L  = 2;
  localparam int BTN_R  = 3;
  localparam int BTN_D  = 4;

  // Press tracking: released, held waiting for first repeat, repeating
  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HELD_WAIT   = 2'd1,
    HELD_REPEAT = 2'd2
  } press_state_t;

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, stability-counter debounce,
// and a press FSM producing a one-cycle strobe with optional auto-repeat.
module btn_chan
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W = $clog2(RMAX);

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  logic              sync1;
  logic              sync2;
  logic [CNT_W-1:0]  cnt;
  logic              level_next;
  logic [RCNT_W-1:0] rcnt;
  press_state_t      state;

  // Two-flop synchroniser; sync2 is the only consumer of the raw input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Level the debouncer will hold after this edge; lets the FSM pulse in
  // the same cycle the debounced level rises
  always_comb begin
    level_next = btn_level;
    if ((sync2 != btn_level) && (cnt == CNT_LAST)) begin
      level_next = sync2;
    end
  end

  // Debounce: accept a change only after it holds for DEBOUNCE_CYCLES edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      btn_level <= 1'b0;
    end else if (sync2 == btn_level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      btn_level <= sync2;
      cnt       <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Press FSM with repeat counter; release always wins over a repeat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RELEASED;
      rcnt      <= '0;
      btn_pulse <= 1'b0;
    end else begin
      btn_pulse <= 1'b0;
      if (!level_next) begin
        state <= RELEASED;
        rcnt  <= '0;
      end else begin
        case (state)
          RELEASED: begin
            btn_pulse <= 1'b1;
            rcnt      <= '0;
            state     <= HELD_WAIT;
          end
          HELD_WAIT: begin
            if (rcnt == DELAY_LAST) begin
              // Non-repeat channels park here with the counter saturated
              if (REPEAT_EN) begin
                btn_pulse <= 1'b1;
                rcnt      <= '0;
                state     <= HELD_REPEAT;
              end
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          HELD_REPEAT: begin
            if (rcnt == PERIOD_LAST) begin
              btn_pulse <= 1'b1;
              rcnt      <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            state <= RELEASED;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel pushbutton conditioner: one independent btn_chan per button,
// auto-repeat enabled per channel by REPEAT_MASK.
module btn_conditioner
  import calc_pkg::*;
#(
  parameter int               N_BTN           = 5,
  parameter int               DEBOUNCE_CYCLES = 1_000_000,
  parameter int               REPEAT_DELAY    = 50_000_000,
  parameter int               REPEAT_PERIOD   = 10_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  // One conditioner per channel; channels share nothing but clock and reset
  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
      btn_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
        .REPEAT_EN      (REPEAT_MASK[gi])
      ) u_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw[gi]),
        .btn_level(btn_level[gi]),
        .btn_pulse(btn_pulse[gi])
      );
    end
  endgenerate

endmodule
